// File: rtl/sample_burst_writer_if.sv
// Arbiter port bundle shared by memory requesters.
// Handshake: the requester holds req (and wr for writes) high for a whole burst and
// presents {addr, data}; one word transfers on every cycle where req && ack, and ack with req low is meaningless.
interface arbiter_if #(
    parameter int AN = 24,
    parameter int DN = 16
) ();
    logic          req;
    logic          wr;
    logic [AN-1:0] addr;
    logic [DN-1:0] data;
    logic          ack;

    modport master (output req, output wr, output addr, output data, input ack);
    modport slave  (input req, input wr, input addr, input data, output ack);
endinterface

// File: rtl/sample_burst_writer.sv
// Captures a LEN-sample window into memory: samples are queued in a FIFO and
// drained as BURST-word write bursts on the arbiter port, starting at BASE.
module sample_burst_writer #(
    parameter int            AN      = 24,
    parameter int            DN      = 16,
    parameter int            SN      = 10,
    parameter int            BURST   = 8,
    parameter logic [AN-1:0] BASE    = 24'he00000,
    parameter int            LEN     = 4096,
    parameter int            FIFO_AW = 5
) (
    input  logic             clkSYS,
    input  logic             reset,
    input  logic             start,
    input  logic             smpl_valid,
    input  logic [SN-1:0]    smpl,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [FIFO_AW:0] level,
    output logic [1:0]       dbg_state,
    arbiter_if.master        bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(LEN + 1);
    localparam int BW    = $clog2(BURST + 1);

    localparam logic [CW-1:0]    LEN_C     = CW'(LEN);
    localparam logic [CW:0]      LAST_RET  = (CW + 1)'(LEN - 1);
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] BURST_L   = (FIFO_AW + 1)'(BURST);
    localparam logic [BW-1:0]    LAST_BEAT = BW'(BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_BURST   = 2'd2,
        S_FLUSH   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      smpl_cnt_q, smpl_cnt_d;
    logic [CW-1:0]      word_cnt_q, word_cnt_d;
    logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [AN-1:0]      addr_q, addr_d;
    logic               req_q, req_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;

    logic [SN-1:0]      fifo_mem [DEPTH];

    logic               window_open;
    logic               take;
    logic               pop;
    logic               fifo_full;
    logic               push;
    logic               drop;
    logic [CW:0]        retired;
    logic               last_word;

    // Intake runs in CAPTURE and BURST until LEN samples have been seen, dropped ones included.
    always_comb begin
        window_open = ((state_q == S_CAPTURE) || (state_q == S_BURST)) && (smpl_cnt_q != LEN_C);
        take        = smpl_valid && window_open;
        pop         = req_q && bus.ack;
        fifo_full   = (level_q == DEPTH_C);
        push        = take && (!fifo_full || pop);
        drop        = take && fifo_full && !pop;
        retired     = {1'b0, word_cnt_q} + {1'b0, drop_cnt_q};
        last_word   = pop && (retired == LAST_RET);
    end

    always_comb begin
        state_d    = state_q;
        smpl_cnt_d = smpl_cnt_q;
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        req_d      = req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (take) smpl_cnt_d = smpl_cnt_q + 1'b1;
        if (drop) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
            ovf_d      = 1'b1;
        end
        // The final word keeps its own address so addr never leaves the window.
        if (pop) begin
            word_cnt_d = word_cnt_q + 1'b1;
            beat_d     = beat_q + 1'b1;
            if (!last_word) addr_d = addr_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CAPTURE;
                    busy_d     = 1'b1;
                    smpl_cnt_d = '0;
                    word_cnt_d = '0;
                    drop_cnt_d = '0;
                    ovf_d      = 1'b0;
                    addr_d     = BASE;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    level_d    = '0;
                end
            end
            S_CAPTURE: begin
                if (level_q >= BURST_L) begin
                    state_d = S_BURST;
                    req_d   = 1'b1;
                    beat_d  = '0;
                end else if (smpl_cnt_q == LEN_C) begin
                    if (level_q != '0) begin
                        state_d = S_FLUSH;
                        req_d   = 1'b1;
                        beat_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_BURST: begin
                if (last_word) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (pop && (beat_q == LAST_BEAT)) begin
                    state_d = S_CAPTURE;
                    req_d   = 1'b0;
                end
            end
            S_FLUSH: begin
                if (last_word) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            smpl_cnt_q <= '0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
            beat_q     <= '0;
            addr_q     <= BASE;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            smpl_cnt_q <= smpl_cnt_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    always_ff @(posedge clkSYS) begin
        if (push) fifo_mem[wr_ptr_q] <= smpl;
    end

    // An empty FIFO presents zero rather than a stale entry.
    assign bus.data  = (level_q == '0) ? '0 : DN'(fifo_mem[rd_ptr_q]);
    assign bus.addr  = addr_q;
    assign bus.req   = req_q;
    assign bus.wr    = req_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign level     = level_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_sample_burst_writer.sv
// Directed bench for sample_burst_writer: a queue-based capture model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_sample_burst_writer;
    localparam int            AN      = 24;
    localparam int            DN      = 16;
    localparam int            SN      = 10;
    localparam int            BURST   = 8;
    localparam int            LEN     = 48;
    localparam int            FIFO_AW = 5;
    localparam int            DEPTH   = 1 << FIFO_AW;
    localparam logic [AN-1:0] BASE    = 24'he00000;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             start      = 1'b0;
    logic             smpl_valid = 1'b0;
    logic [SN-1:0]    smpl       = '0;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [FIFO_AW:0] level;
    logic [1:0]       dbg_state;

    arbiter_if #(.AN(AN), .DN(DN)) bus ();

    sample_burst_writer #(
        .AN(AN), .DN(DN), .SN(SN), .BURST(BURST),
        .BASE(BASE), .LEN(LEN), .FIFO_AW(FIFO_AW)
    ) dut (
        .clkSYS     (clk),
        .reset      (rst),
        .start      (start),
        .smpl_valid (smpl_valid),
        .smpl       (smpl),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .level      (level),
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Capture model: exp_q holds the words the FIFO must contain, in order.
    logic [DN-1:0] exp_q[$];
    logic [DN-1:0] wr_log[$];
    bit            m_active;
    bit            m_ovf;
    bit            m_done;
    int            m_nsmpl;
    int            m_ndrop;
    int            m_nwritten;
    logic [AN-1:0] m_addr;
    int            done_cnt       = 0;
    int            burst_acks     = 0;
    int            last_burst_len = 0;
    int            peak_level     = 0;
    bit            prev_req       = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        m_active   = 1'b0;
        m_ovf      = 1'b0;
        m_done     = 1'b0;
        m_nsmpl    = 0;
        m_ndrop    = 0;
        m_nwritten = 0;
        m_addr     = BASE;
    endtask

    task automatic compare_outputs();
        logic [DN-1:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : '0;
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
        check("level", level, exp_q.size());
        check("addr", bus.addr, m_addr);
        check("data", bus.data, head);
        check("wr_follows_req", bus.wr, bus.req);
        check("req_only_when_busy", bus.req && !m_active, 0);
    endtask

    task automatic model_step();
        bit pop;
        bit take;
        bit was_active;
        int sz;
        m_done     = 1'b0;
        was_active = m_active;
        pop        = (bus.req === 1'b1) && (bus.ack === 1'b1);
        sz         = exp_q.size();
        take       = m_active && smpl_valid && (m_nsmpl < LEN);
        if (pop) begin
            check("pop_nonempty", sz > 0, 1);
            if (sz > 0) void'(exp_q.pop_front());
            m_nwritten++;
        end
        if (take) begin
            m_nsmpl++;
            if (sz < DEPTH || pop) exp_q.push_back(DN'(smpl));
            else begin
                m_ndrop++;
                m_ovf = 1'b1;
            end
        end
        if (pop) begin
            if (m_nsmpl == LEN && exp_q.size() == 0) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end else begin
                m_addr = m_addr + 1'b1;
            end
        end
        if (start && !was_active) begin
            exp_q.delete();
            m_active   = 1'b1;
            m_ovf      = 1'b0;
            m_nsmpl    = 0;
            m_ndrop    = 0;
            m_nwritten = 0;
            m_addr     = BASE;
        end
    endtask

    // Outputs are compared on the falling edge; the model then advances by what the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            model_reset();
            compare_outputs();
            prev_req   = 1'b0;
            burst_acks = 0;
        end else begin
            compare_outputs();
            if (done === 1'b1) done_cnt++;
            if (prev_req && bus.req !== 1'b1) begin
                last_burst_len = burst_acks;
                if (done === 1'b1) check("burst_len_final", (burst_acks >= 1) && (burst_acks <= BURST), 1);
                else               check("burst_len", burst_acks, BURST);
                burst_acks = 0;
            end
            if (bus.req === 1'b1 && bus.ack === 1'b1) begin
                burst_acks++;
                wr_log.push_back(bus.data);
            end
            prev_req = (bus.req === 1'b1);
            if (int'(level) > peak_level) peak_level = int'(level);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int sent;
        int bad;
        int d0;

        bus.ack = 1'b0;
        repeat (2) tick();
        check("rst_req", bus.req, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_addr", bus.addr, 24'he00000);
        check("rst_data", bus.data, 0);
        rst = 1'b0;
        tick();

        // ack while idle must not move anything
        bus.ack = 1'b1;
        repeat (4) tick();
        check("idle_ack_addr", bus.addr, 24'he00000);
        check("idle_ack_level", level, 0);
        check("idle_ack_data", bus.data, 0);
        check("idle_ack_req", bus.req, 0);
        bus.ack = 1'b0;

        // A: 10'h3FF every 4th cycle, ack held high, stray start mid-capture
        wr_log.delete();
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start   = 1'b0;
        bus.ack = 1'b1;
        c       = 0;
        sent    = 0;
        while (done_cnt == d0 && c < 2000) begin
            if (c == 16) begin
                check("A_prefill_level", level, 4);
                check("A_prefill_addr", bus.addr, 24'he00000);
            end
            smpl_valid = ((c % 4) == 0) && (sent < LEN);
            smpl       = 10'h3FF;
            if (smpl_valid) sent++;
            start = (c == 60);
            tick();
            c++;
        end
        smpl_valid = 1'b0;
        start      = 1'b0;
        repeat (5) tick();
        check("A_done_once", done_cnt - d0, 1);
        check("A_words", wr_log.size(), 48);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] !== 16'h03FF) bad++;
        check("A_data_3ff", bad, 0);
        check("A_final_addr", bus.addr, 24'he0002f);
        check("A_overflow", overflow, 0);
        check("A_busy_after", busy, 0);

        // B: ramp every cycle, ack on alternate cycles
        wr_log.delete();
        peak_level = 0;
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        c     = 0;
        sent  = 0;
        while (done_cnt == d0 && c < 2000) begin
            smpl_valid = (sent < LEN);
            smpl       = SN'(sent);
            if (smpl_valid) sent++;
            bus.ack = c[0];
            tick();
            c++;
        end
        smpl_valid = 1'b0;
        bus.ack    = 1'b0;
        repeat (3) tick();
        check("B_done", done_cnt - d0, 1);
        check("B_words", wr_log.size(), 48);
        bad = 0;
        foreach (wr_log[i]) if (wr_log[i] !== 16'(i)) bad++;
        check("B_ramp_order", bad, 0);
        check("B_peak_le_depth", peak_level <= 32, 1);
        check("B_overflow", overflow, 0);

        // C: ack held low 200 cycles while 45 samples stream, then 3 late samples
        wr_log.delete();
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start   = 1'b0;
        bus.ack = 1'b0;
        for (int k = 0; k < 200; k++) begin
            smpl_valid = (k < 45);
            smpl       = SN'(k);
            tick();
        end
        smpl_valid = 1'b0;
        check("C_level_full", level, 32);
        check("C_overflow_set", overflow, 1);
        check("C_req_held", bus.req, 1);
        check("C_model_drops", m_ndrop, 13);
        bus.ack = 1'b1;
        c       = 0;
        sent    = 0;
        while (done_cnt == d0 && c < 2000) begin
            smpl_valid = ((c % 4) == 0) && (sent < 3);
            smpl       = SN'(100 + sent);
            if (smpl_valid) sent++;
            tick();
            c++;
        end
        smpl_valid = 1'b0;
        bus.ack    = 1'b0;
        repeat (3) tick();
        check("C_done", done_cnt - d0, 1);
        check("C_words", wr_log.size(), 35);
        bad = 0;
        foreach (wr_log[i]) begin
            if (i < 32) begin
                if (wr_log[i] !== 16'(i)) bad++;
            end else if (wr_log[i] !== 16'(100 + i - 32)) bad++;
        end
        check("C_data", bad, 0);
        check("C_flush_len", last_burst_len, 3);
        check("C_final_addr", bus.addr, 24'he00022);
        check("C_overflow_sticky", overflow, 1);

        // D: reset in the middle of a burst after 3 acks, then a clean capture
        start = 1'b1;
        tick();
        start = 1'b0;
        check("D_overflow_cleared", overflow, 0);
        check("D_start_addr", bus.addr, 24'he00000);
        c = 0;
        while (bus.req !== 1'b1 && c < 50) begin
            smpl_valid = 1'b1;
            smpl       = SN'(c);
            tick();
            c++;
        end
        check("D_req_rise", bus.req, 1);
        smpl_valid = 1'b0;
        bus.ack    = 1'b1;
        repeat (3) tick();
        bus.ack = 1'b0;
        check("D_addr_3acks", bus.addr, 24'he00003);
        #2;
        rst = 1'b1;
        #1;
        check("D_rst_req", bus.req, 0);
        check("D_rst_wr", bus.wr, 0);
        check("D_rst_level", level, 0);
        check("D_rst_busy", busy, 0);
        check("D_rst_addr", bus.addr, 24'he00000);
        tick();
        rst = 1'b0;
        tick();
        wr_log.delete();
        d0    = done_cnt;
        start = 1'b1;
        tick();
        start   = 1'b0;
        bus.ack = 1'b1;
        c       = 0;
        sent    = 0;
        while (done_cnt == d0 && c < 2000) begin
            smpl_valid = (sent < LEN);
            smpl       = SN'(sent + 7);
            if (smpl_valid) sent++;
            tick();
            c++;
        end
        smpl_valid = 1'b0;
        bus.ack    = 1'b0;
        repeat (3) tick();
        check("D_done", done_cnt - d0, 1);
        check("D_words", wr_log.size(), 48);
        check("D_first_word", (wr_log.size() > 0) ? wr_log[0] : 16'hffff, 16'h0007);
        check("D_final_addr", bus.addr, 24'he0002f);
        check("D_overflow", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
